// File: rtl/uart_rx_fact_engine.sv
// UART receiver feeding an iterative n! engine (one multiply per clock).
// Optional parity stage and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_fact_engine #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int RES_W      = 32
`ifdef UART_RX_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             s_tick,
  output logic             rx_done_tick,
  output logic [DBIT-1:0]  dout,
  output logic             frame_err,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             res_ovf
);

  localparam int SMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int NW   = $clog2(DBIT + 1);
  localparam int IW   = DBIT + 1;
  localparam int PW   = RES_W + DBIT;

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif
  typedef enum logic [1:0] {F_IDLE, F_CALC, F_HOLD} f_state_t;

  rx_state_t       rx_state, rx_state_n;
  logic [SW-1:0]   s_q, s_n;
  logic [NW-1:0]   n_q, n_n;
  logic [DBIT-1:0] b_q, b_n, dout_n;
  logic            done_n, ferr_n;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_n, perr_n, par_bad;
  assign par_bad = ((^b_q) ^ par_q) != 1'(PARITY_ODD);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state     <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_state     <= rx_state_n;
      s_q          <= s_n;
      n_q          <= n_n;
      b_q          <= b_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_n;
      parity_err   <= perr_n;
`endif
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    s_n        = s_q;
    n_n        = n_q;
    b_n        = b_q;
    dout_n     = dout;
    done_n     = 1'b0;
    ferr_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n      = par_q;
    perr_n     = 1'b0;
`endif
    unique case (rx_state)
      IDLE: begin
        if (!rx) begin
          rx_state_n = START;
          s_n        = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_HALF) begin
            s_n        = '0;
            n_n        = '0;
            rx_state_n = rx ? IDLE : DATA;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_n = '0;
            b_n = {rx, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              rx_state_n = PARITY;
`else
              rx_state_n = STOP;
`endif
            end else begin
              n_n = n_q + 1'b1;
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_n        = '0;
            par_n      = rx;
            rx_state_n = STOP;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            rx_state_n = IDLE;
            ferr_n     = !rx;
`ifdef UART_RX_PARITY_EN
            perr_n     = par_bad;
            if (rx && !par_bad) begin
`else
            if (rx) begin
`endif
              done_n = 1'b1;
              dout_n = b_q;
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  f_state_t        f_state, f_state_n;
  logic [RES_W-1:0] acc;
  logic [IW-1:0]    i_q;
  logic [DBIT-1:0]  n_lat;
  logic             ovf;
  logic [PW-1:0]    prod;
  logic             calc_done;

  // i never exceeds n while multiplying, so its low DBIT bits suffice
  assign prod      = PW'(acc) * PW'(i_q[DBIT-1:0]);
  assign calc_done = i_q > {1'b0, n_lat};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) f_state <= F_IDLE;
    else       f_state <= f_state_n;
  end

  always_comb begin
    f_state_n = f_state;
    unique case (f_state)
      F_IDLE: if (rx_done_tick) f_state_n = F_CALC;
      F_CALC: if (calc_done)    f_state_n = F_HOLD;
      F_HOLD: if (res_ready)    f_state_n = F_IDLE;
      default: f_state_n = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      i_q     <= '0;
      n_lat   <= '0;
      ovf     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (f_state == F_IDLE && rx_done_tick) begin
        n_lat <= dout;
        acc   <= RES_W'(1);
        i_q   <= IW'(2);
        ovf   <= 1'b0;
      end
      if (f_state == F_CALC && !calc_done) begin
        acc <= prod[RES_W-1:0];
        i_q <= i_q + 1'b1;
        if (|prod[PW-1:RES_W]) ovf <= 1'b1;
      end
      // a dropped byte wins over a same-cycle handshake clear
      if (rx_done_tick && f_state != F_IDLE)
        overrun <= 1'b1;
      else if (f_state == F_HOLD && res_ready)
        overrun <= 1'b0;
    end
  end

  assign busy      = f_state != F_IDLE;
  assign res_valid = f_state == F_HOLD;
  assign res_data  = res_valid ? acc : '0;
  assign res_ovf   = res_valid & ovf;

endmodule

// File: tb/tb_uart_rx_fact_engine.sv
// Bench for uart_rx_fact_engine: serial frames in, n! results checked
// against an arithmetic factorial model.
module tb_uart_rx_fact_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        s_tick;
  logic        rx_done_tick;
  logic [7:0]  dout;
  logic        frame_err;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif
  logic        overrun;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_ovf;

  uart_rx_fact_engine dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .s_tick(s_tick),
    .rx_done_tick(rx_done_tick),
    .dout(dout),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun),
    .busy(busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  // one oversample tick every second clock: 32 clocks per bit
  always @(negedge clk) s_tick = ~s_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          done_cyc[$];
  logic [7:0]  done_val[$];
  int          res_cyc[$];
  logic [31:0] res_dat[$];
  bit          res_o[$];
  int          ferr_n;
  int          perr_n;
  bit          busy_seen;
  bit          pv = 1'b0;
  logic [7:0]  last_good;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cyc.push_back(cyc);
      done_val.push_back(dout);
    end
    if (frame_err) ferr_n++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_n++;
`endif
    if (busy) busy_seen = 1'b1;
    if (res_valid && !pv) begin
      res_cyc.push_back(cyc);
      res_dat.push_back(res_data);
      res_o.push_back(res_ovf);
    end
    pv = res_valid;
  end

  function automatic void fact_model(input int n, output logic [31:0] v,
                                     output bit o);
    logic [63:0] exact;
    v = 32'd1;
    exact = 64'd1;
    o = 1'b0;
    for (int k = 2; k <= n; k++) begin
      v = v * 32'(k);
      if (!o) begin
        exact = exact * 64'(k);
        if (exact[63:32] != 0) o = 1'b1;
      end
    end
  endfunction

  function automatic int lat_model(input int n);
    return (n < 1) ? 2 : n + 1;
  endfunction

  task automatic clear_mon;
    done_cyc.delete();
    done_val.delete();
    res_cyc.delete();
    res_dat.delete();
    res_o.delete();
    ferr_n = 0;
    perr_n = 0;
    busy_seen = 1'b0;
  endtask

  task automatic send_head(input logic [7:0] d, input bit par_flip);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      repeat (32) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (32) @(negedge clk);
`else
    if (par_flip) rx = 1'b1;
`endif
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok,
                           input bit par_flip);
    send_head(d, par_flip);
    if (stop_ok) begin
      rx = 1'b1;
      repeat (32) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (24) @(negedge clk);
      rx = 1'b1;
      repeat (8) @(negedge clk);
    end
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0h want 0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0h want 0", res_valid); end
    total++; if (res_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %0h want 0", res_data); end
    total++; if (dout !== 8'h0) begin bad++; $display("FAIL rst_dout: got %0h want 0", dout); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %0h want 0", overrun); end
    total++; if ({rx_done_tick, frame_err, res_ovf} !== 3'b0) begin bad++; $display("FAIL rst_pulses: got %0h want 0", {rx_done_tick, frame_err, res_ovf}); end
    reset = 1'b0;
    last_good = 8'h0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_fact5;
    logic [31:0] ev;
    bit eo;
    fact_model(5, ev, eo);
    clear_mon();
    send_byte(8'h05, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    last_good = 8'h05;
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL f5_done_cnt: got %0d want 1", done_cyc.size()); end
    total++; if (dout !== 8'h05) begin bad++; $display("FAIL f5_dout: got %0h want 05", dout); end
    total++;
    if (res_cyc.size() !== 1 || done_cyc.size() !== 1) begin
      bad++; $display("FAIL f5_res_cnt: got %0d want 1", res_cyc.size());
    end else begin
      if (res_cyc[0] - done_cyc[0] !== 6) begin bad++; $display("FAIL f5_latency: got %0d want 6", res_cyc[0] - done_cyc[0]); end
      total++; if (res_dat[0] !== ev) begin bad++; $display("FAIL f5_data: got %0d want %0d", res_dat[0], ev); end
      total++; if (res_o[0] !== eo) begin bad++; $display("FAIL f5_ovf: got %0h want %0h", res_o[0], eo); end
    end
  endtask

  task automatic test_small;
    logic [7:0] vals[3];
    logic [31:0] ev;
    bit eo;
    vals[0] = 8'h00; vals[1] = 8'h01; vals[2] = 8'h0C;
    for (int t = 0; t < 3; t++) begin
      fact_model(int'(vals[t]), ev, eo);
      clear_mon();
      send_byte(vals[t], 1'b1, 1'b0);
      repeat (300) @(negedge clk);
      last_good = vals[t];
      total++;
      if (res_cyc.size() !== 1 || done_cyc.size() !== 1) begin
        bad++; $display("FAIL small_cnt n=%0d: got %0d want 1", vals[t], res_cyc.size());
      end else begin
        if (res_cyc[0] - done_cyc[0] !== lat_model(int'(vals[t]))) begin
          bad++; $display("FAIL small_lat n=%0d: got %0d want %0d", vals[t], res_cyc[0] - done_cyc[0], lat_model(int'(vals[t])));
        end
        total++; if (res_dat[0] !== ev) begin bad++; $display("FAIL small_data n=%0d: got %0h want %0h", vals[t], res_dat[0], ev); end
        total++; if (res_o[0] !== eo) begin bad++; $display("FAIL small_ovf n=%0d: got %0h want %0h", vals[t], res_o[0], eo); end
      end
    end
  endtask

  task automatic test_ovf_overrun;
    logic [31:0] ev;
    bit eo;
    fact_model(13, ev, eo);
    res_ready = 1'b0;
    clear_mon();
    send_byte(8'h0D, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    last_good = 8'h0D;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %0h want 1", res_valid); end
    total++; if (res_data !== ev) begin bad++; $display("FAIL ovf_data: got %0h want %0h", res_data, ev); end
    total++; if (res_ovf !== eo) begin bad++; $display("FAIL ovf_flag: got %0h want %0h", res_ovf, eo); end
    clear_mon();
    send_byte(8'h03, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    last_good = 8'h03;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %0h want 1", overrun); end
    total++; if (res_data !== ev) begin bad++; $display("FAIL ovr_data_hold: got %0h want %0h", res_data, ev); end
    total++; if (dout !== 8'h03) begin bad++; $display("FAIL ovr_dout: got %0h want 03", dout); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL hs_valid: got %0h want 0", res_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL hs_overrun: got %0h want 0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hs_busy: got %0h want 0", busy); end
    res_ready = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch_ferr;
    clear_mon();
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    total++; if (done_cyc.size() !== 0) begin bad++; $display("FAIL glitch_done: got %0d want 0", done_cyc.size()); end
    total++; if (ferr_n !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", ferr_n); end
    clear_mon();
    send_byte(8'hA5, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    total++; if (ferr_n !== 1) begin bad++; $display("FAIL ferr_cnt: got %0d want 1", ferr_n); end
    total++; if (done_cyc.size() !== 0) begin bad++; $display("FAIL ferr_done: got %0d want 0", done_cyc.size()); end
    total++; if (dout !== last_good) begin bad++; $display("FAIL ferr_dout: got %0h want %0h", dout, last_good); end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL ferr_busy: got %0h want 0", busy_seen); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    logic [31:0] ev;
    bit eo;
    res_ready = 1'b1;
    clear_mon();
    send_head(8'h0A, 1'b0);
    rx = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_calc_start: got 0 want 1"); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0h want 0", busy); end
    total++; if (dout !== 8'h0) begin bad++; $display("FAIL mid_dout: got %0h want 0", dout); end
    total++; if ({res_valid, res_ovf, overrun} !== 3'b0) begin bad++; $display("FAIL mid_flags: got %0h want 0", {res_valid, res_ovf, overrun}); end
    total++; if (res_data !== 32'h0) begin bad++; $display("FAIL mid_data: got %0h want 0", res_data); end
    last_good = 8'h0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (res_cyc.size() !== 0) begin bad++; $display("FAIL mid_partial: got %0d want 0", res_cyc.size()); end
    fact_model(4, ev, eo);
    clear_mon();
    send_byte(8'h04, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    last_good = 8'h04;
    total++;
    if (res_dat.size() !== 1) begin
      bad++; $display("FAIL mid_after_cnt: got %0d want 1", res_dat.size());
    end else if (res_dat[0] !== ev) begin
      bad++; $display("FAIL mid_after_data: got %0d want %0d", res_dat[0], ev);
    end
  endtask

  task automatic test_random;
    logic [7:0] d;
    bit stop_ok;
    logic [31:0] ev;
    bit eo;
    for (int t = 0; t < 16; t++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 14));
      stop_ok = $urandom_range(0, 4) != 0;
      fact_model(int'(d), ev, eo);
      clear_mon();
      send_byte(d, stop_ok, 1'b0);
      repeat (300) @(negedge clk);
      if (!stop_ok) begin
        total++; if (ferr_n !== 1) begin bad++; $display("FAIL rnd_ferr d=%0h: got %0d want 1", d, ferr_n); end
        total++; if (res_cyc.size() !== 0 || done_cyc.size() !== 0) begin bad++; $display("FAIL rnd_bad_start d=%0h: got %0d want 0", d, res_cyc.size()); end
        total++; if (dout !== last_good) begin bad++; $display("FAIL rnd_dout_hold: got %0h want %0h", dout, last_good); end
      end else begin
        last_good = d;
        total++;
        if (done_val.size() !== 1 || res_cyc.size() !== 1) begin
          bad++; $display("FAIL rnd_cnt d=%0h: got %0d/%0d want 1/1", d, done_val.size(), res_cyc.size());
        end else begin
          if (done_val[0] !== d) begin bad++; $display("FAIL rnd_dout: got %0h want %0h", done_val[0], d); end
          total++; if (res_cyc[0] - done_cyc[0] !== lat_model(int'(d))) begin bad++; $display("FAIL rnd_lat d=%0h: got %0d want %0d", d, res_cyc[0] - done_cyc[0], lat_model(int'(d))); end
          total++; if (res_dat[0] !== ev) begin bad++; $display("FAIL rnd_data d=%0h: got %0h want %0h", d, res_dat[0], ev); end
          total++; if (res_o[0] !== eo) begin bad++; $display("FAIL rnd_ovf d=%0h: got %0h want %0h", d, res_o[0], eo); end
        end
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    logic [31:0] ev;
    bit eo;
    clear_mon();
    send_byte(8'h07, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    total++; if (perr_n !== 1) begin bad++; $display("FAIL par_err: got %0d want 1", perr_n); end
    total++; if (busy_seen !== 1'b0 || done_cyc.size() !== 0) begin bad++; $display("FAIL par_start: got %0h want 0", busy_seen); end
    total++; if (dout !== last_good) begin bad++; $display("FAIL par_dout: got %0h want %0h", dout, last_good); end
    fact_model(7, ev, eo);
    clear_mon();
    send_byte(8'h07, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    last_good = 8'h07;
    total++;
    if (res_dat.size() !== 1) begin
      bad++; $display("FAIL par_ok_cnt: got %0d want 1", res_dat.size());
    end else if (res_dat[0] !== ev) begin
      bad++; $display("FAIL par_ok_data: got %0d want %0d", res_dat[0], ev);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    s_tick = 1'b0;
    res_ready = 1'b1;
    ferr_n = 0;
    perr_n = 0;
    busy_seen = 1'b0;
    last_good = 8'h0;
    test_reset();
    test_fact5();
    test_small();
    test_ovf_overrun();
    test_glitch_ferr();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
